// File: rtl/fp_div_arb_pkg.sv
// Shared widths, saturation constants and tag record for the fp_Divide arbiter.
package fp_div_arb_pkg;

  // Ceiling log2, never less than 1 so single-bit fields stay legal.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned ARB_NREQ    = 4;
  localparam int unsigned ARB_DIV_LAT = 4;
  localparam int unsigned WI1 = 12;
  localparam int unsigned WF1 = 12;
  localparam int unsigned WI2 = 12;
  localparam int unsigned WF2 = 12;
  localparam int unsigned WIO = 12;
  localparam int unsigned WFO = 12;
  localparam int unsigned WL1 = WI1 + WF1;
  localparam int unsigned WL2 = WI2 + WF2;
  localparam int unsigned WLO = WIO + WFO;
  localparam int unsigned ID_W = log2(ARB_NREQ);

  localparam logic [WLO-1:0] SAT_POS = {1'b0, {(WLO-1){1'b1}}};
  localparam logic [WLO-1:0] SAT_NEG = {1'b1, {(WLO-1){1'b0}}};

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic            dz;
    logic [WLO-1:0]  sat;
  } tag_t;

  // Result substituted for a divide-by-zero, following the dividend sign.
  function automatic logic [WLO-1:0] sat_value(input logic [WL1-1:0] op1);
    logic [WLO-1:0] r;
    if (op1[WL1-1])       r = SAT_NEG;
    else if (op1 == '0)   r = '0;
    else                  r = SAT_POS;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_c,
  output logic [PTR_W-1:0] grant_idx_c
);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] cand;
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found         = 1'b1;
        grant_c[cand] = 1'b1;
        grant_idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/fp_divide_arbiter.sv
// Shares one pipelined fp_Divide among NREQ requesters; tags track each
// operation so the quotient (or a divide-by-zero saturation) returns to its owner.
module fp_divide_arbiter
  import fp_div_arb_pkg::*;
#(
  parameter int unsigned NREQ    = ARB_NREQ,
  parameter int unsigned DIV_LAT = ARB_DIV_LAT
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          HOLD,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*WL1-1:0]           req_op1,
  input  logic [NREQ*WL2-1:0]           req_op2,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [WLO-1:0]                rsp_data,
  output logic                          rsp_dz,
  output logic                          div_CE,
  output logic [WL1-1:0]                div_OP1,
  output logic [WL2-1:0]                div_OP2,
  input  logic [WLO-1:0]                div_dout,
  output logic [log2(DIV_LAT+2)-1:0]    inflight
);

  localparam int unsigned CNT_W  = log2(DIV_LAT + 2);
  localparam int unsigned STAGES = DIV_LAT + 2;

  logic [NREQ-1:0] grant_c;
  logic [ID_W-1:0] grant_idx_c;
  logic [ID_W-1:0] ptr_q;
  logic            hs_c;
  logic [WL1-1:0]  op1_c;
  logic [WL2-1:0]  op2_c;
  tag_t            new_tag_c;
  tag_t            tail;
  tag_t            tag_q [STAGES];

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (ID_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign req_ready = (RST || HOLD) ? '0 : grant_c;
  assign hs_c      = |(req_valid & req_ready);
  assign div_CE    = ~RST & ~HOLD;

  // Operand mux for the granted requester.
  always_comb begin
    op1_c = '0;
    op2_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) begin
        op1_c = req_op1[i*WL1 +: WL1];
        op2_c = req_op2[i*WL2 +: WL2];
      end
    end
  end

  always_comb begin
    new_tag_c = '0;
    if (hs_c) begin
      new_tag_c.v   = 1'b1;
      new_tag_c.id  = grant_idx_c;
      new_tag_c.dz  = (op2_c == '0);
      new_tag_c.sat = new_tag_c.dz ? sat_value(op1_c) : '0;
    end
  end

  // Stages 0..DIV_LAT are in flight; the last stage holds the result being presented.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q    <= ID_W'(NREQ - 1);
      div_OP1  <= '0;
      div_OP2  <= '0;
      inflight <= '0;
      for (int unsigned i = 0; i < STAGES; i++) tag_q[i] <= '0;
    end else if (!HOLD) begin
      tag_q[0] <= new_tag_c;
      for (int unsigned i = 1; i < STAGES; i++) tag_q[i] <= tag_q[i-1];
      inflight <= inflight + CNT_W'(new_tag_c.v) - CNT_W'(tag_q[DIV_LAT].v);
      if (hs_c) begin
        ptr_q   <= grant_idx_c;
        div_OP1 <= new_tag_c.dz ? '0 : op1_c;
        div_OP2 <= new_tag_c.dz ? '0 : op2_c;
      end
    end
  end

  assign tail = tag_q[STAGES-1];

  always_comb begin
    rsp_valid = '0;
    if (tail.v && !HOLD) rsp_valid[tail.id] = 1'b1;
  end

  assign rsp_data = !tail.v ? '0 : (tail.dz ? tail.sat : div_dout);
  assign rsp_dz   = tail.v & tail.dz;

endmodule

// File: tb/tb_fp_divide_arbiter.sv
// Bench for fp_divide_arbiter: behavioural fp_Divide, scoreboard model, directed and random traffic.
module tb_fp_divide_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DIV_LAT = 4;
  localparam int unsigned WL      = 24;
  localparam int unsigned CNT_W   = 3;

  logic                 CLK, RST, HOLD;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid;
  logic [NREQ*WL-1:0]   req_op1, req_op2;
  logic [WL-1:0]        rsp_data, div_OP1, div_OP2, div_dout;
  logic                 rsp_dz, div_CE;
  logic [CNT_W-1:0]     inflight;

  fp_divide_arbiter #(.NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .RST(RST), .HOLD(HOLD),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_dz(rsp_dz),
    .div_CE(div_CE), .div_OP1(div_OP1), .div_OP2(div_OP2),
    .div_dout(div_dout), .inflight(inflight)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Signed fixed-point Q12.12 division, truncating toward zero.
  function automatic logic [WL-1:0] qdiv(input logic [WL-1:0] a, input logic [WL-1:0] b);
    longint na, nb, q;
    na = longint'($signed(a));
    nb = longint'($signed(b));
    if (nb == 0) return '0;
    q = (na * 4096) / nb;
    return q[WL-1:0];
  endfunction

  function automatic logic [WL-1:0] sat_of(input logic [WL-1:0] a);
    if ($signed(a) > 0) return 24'h7FFFFF;
    if ($signed(a) < 0) return 24'h800000;
    return 24'h000000;
  endfunction

  // fp_Divide stand-in: operands sampled with CE, quotient visible DIV_LAT edges later.
  logic [WL-1:0] dpipe [DIV_LAT+1];
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i <= DIV_LAT; i++) dpipe[i] <= '0;
    end else if (div_CE) begin
      dpipe[0] <= qdiv(div_OP1, div_OP2);
      for (int i = 1; i <= DIV_LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_dout = dpipe[DIV_LAT];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: each accepted request is presented when the active-edge count reaches due.
  typedef struct {
    int            id;
    logic [WL-1:0] data;
    logic          dz;
    int            due;
  } exp_t;
  exp_t sb[$];
  int   t;
  int   m_ptr;
  logic chk_en;

  logic [WL-1:0]   op1_a [NREQ];
  logic [WL-1:0]   op2_a [NREQ];
  logic [NREQ-1:0] s_rv, s_gnt;
  logic [WL-1:0]   s_data;
  logic            s_dz;
  int              s_infl;

  task automatic cycle(input logic [NREQ-1:0] v, input logic hold, input logic rst);
    int g, found, einf, i;
    logic [NREQ-1:0] erdy, erv;
    @(negedge CLK);
    RST = rst;
    HOLD = hold;
    req_valid = v;
    for (int k = 0; k < NREQ; k++) begin
      req_op1[k*WL +: WL] = op1_a[k];
      req_op2[k*WL +: WL] = op2_a[k];
    end
    #1;
    s_rv = rsp_valid; s_gnt = req_ready; s_data = rsp_data; s_dz = rsp_dz; s_infl = int'(inflight);
    g = -1;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (g < 0 && v[i]) g = i;
      end
    end
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(erdy));
      chk("div_CE", 32'(div_CE), 32'(!rst && !hold));
      found = -1;
      foreach (sb[j]) if (sb[j].due == t) found = j;
      erv = '0;
      if (found >= 0 && !hold) erv[sb[found].id] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      if (found >= 0) begin
        chk("rsp_data", 32'(rsp_data), 32'(sb[found].data));
        chk("rsp_dz", 32'(rsp_dz), 32'(sb[found].dz));
      end else begin
        chk("rsp_data_idle", 32'(rsp_data), 32'd0);
        chk("rsp_dz_idle", 32'(rsp_dz), 32'd0);
      end
      einf = 0;
      foreach (sb[j]) if (sb[j].due > t) einf++;
      chk("inflight", 32'(inflight), 32'(einf));
    end
    if (rst) begin
      sb.delete();
      m_ptr = NREQ - 1;
      t = 0;
    end else if (!hold) begin
      exp_t e;
      t++;
      while (sb.size() > 0 && sb[0].due < t) void'(sb.pop_front());
      if (g >= 0) begin
        e.id   = g;
        e.dz   = (op2_a[g] == '0);
        e.data = e.dz ? sat_of(op1_a[g]) : qdiv(op1_a[g], op2_a[g]);
        e.due  = t + DIV_LAT + 1;
        sb.push_back(e);
        m_ptr = g;
      end
    end
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++) begin
      op1_a[k] = ($urandom_range(0, 9) == 0) ? '0 : WL'($urandom);
      op2_a[k] = ($urandom_range(0, 7) == 0) ? '0 : WL'($urandom);
    end
  endtask

  typedef struct {
    int            id;
    logic [WL-1:0] op1;
    logic [WL-1:0] op2;
    logic [WL-1:0] exp_data;
    logic          exp_dz;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int seen, peak, infl0;
    logic [NREQ-1:0] seen_rv;
    logic [WL-1:0]   seen_data;
    logic            seen_dz;

    tbl[0] = '{0, 24'h001800, 24'h009800, 24'h000286, 1'b0};
    tbl[1] = '{2, 24'h059800, 24'h000000, 24'h7FFFFF, 1'b1};
    tbl[2] = '{2, 24'hFFF000, 24'h000000, 24'h800000, 1'b1};
    tbl[3] = '{2, 24'h000000, 24'h000000, 24'h000000, 1'b1};
    tbl[4] = '{1, 24'hFFE000, 24'h001000, 24'hFFE000, 1'b0};
    tbl[5] = '{3, 24'h003000, 24'hFFF800, 24'hFFA000, 1'b0};

    RST = 1'b1; HOLD = 1'b0; req_valid = '0; req_op1 = '0; req_op2 = '0;
    for (int k = 0; k < NREQ; k++) begin op1_a[k] = '0; op2_a[k] = '0; end
    chk_en = 1'b0; t = 0; m_ptr = NREQ - 1;
    cycle('0, 1'b0, 1'b1);
    cycle('0, 1'b0, 1'b1);
    chk_en = 1'b1;

    // Reset state
    cycle('0, 1'b0, 1'b0);
    chk("rst_ready", 32'(s_gnt), 32'd0);
    chk("rst_rsp_valid", 32'(s_rv), 32'd0);
    chk("rst_rsp_data", 32'(s_data), 32'd0);
    chk("rst_rsp_dz", 32'(s_dz), 32'd0);
    chk("rst_div_OP1", 32'(div_OP1), 32'd0);
    chk("rst_div_OP2", 32'(div_OP2), 32'd0);
    chk("rst_inflight", 32'(s_infl), 32'd0);

    // Directed single requests: latency, quotient and saturation
    foreach (tbl[n]) begin
      op1_a[tbl[n].id] = tbl[n].op1;
      op2_a[tbl[n].id] = tbl[n].op2;
      cycle(NREQ'(1) << tbl[n].id, 1'b0, 1'b0);
      seen = -1; seen_rv = '0; seen_data = '0; seen_dz = 1'b0;
      for (int j = 1; j <= DIV_LAT + 6; j++) begin
        cycle('0, 1'b0, 1'b0);
        if (j == 1) chk("tbl_div_OP1", 32'(div_OP1), tbl[n].exp_dz ? 32'd0 : 32'(tbl[n].op1));
        if (s_rv != '0 && seen < 0) begin
          seen = j; seen_rv = s_rv; seen_data = s_data; seen_dz = s_dz;
        end
      end
      chk("tbl_latency", 32'(seen), 32'(DIV_LAT + 2));
      chk("tbl_rsp_valid", 32'(seen_rv), 32'(1) << tbl[n].id);
      chk("tbl_rsp_data", 32'(seen_data), 32'(tbl[n].exp_data));
      chk("tbl_rsp_dz", 32'(seen_dz), 32'(tbl[n].exp_dz));
    end

    // Round-robin fairness with all requesters valid
    cycle('0, 1'b0, 1'b1);
    peak = 0;
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      cycle('1, 1'b0, 1'b0);
      chk("rr_grant", 32'(s_gnt), 32'(1) << (c % NREQ));
      if (s_infl > peak) peak = s_infl;
    end
    for (int c = 0; c < DIV_LAT + 6; c++) begin
      cycle('0, 1'b0, 1'b0);
      if (s_infl > peak) peak = s_infl;
    end
    chk("rr_inflight_peak", 32'(peak), 32'(DIV_LAT + 1));

    // HOLD with three results in flight
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      cycle(4'b0111, 1'b0, 1'b0);
    end
    cycle('0, 1'b0, 1'b0);
    infl0 = s_infl;
    for (int c = 0; c < 3; c++) begin
      cycle('1, 1'b1, 1'b0);
      chk("hold_ready", 32'(s_gnt), 32'd0);
      chk("hold_rsp_valid", 32'(s_rv), 32'd0);
      chk("hold_inflight", 32'(s_infl), 32'(infl0));
    end
    for (int c = 0; c < DIV_LAT + 6; c++) cycle('0, 1'b0, 1'b0);

    // Reset with four results in flight
    for (int c = 0; c < 4; c++) begin
      rand_ops();
      cycle('1, 1'b0, 1'b0);
    end
    cycle('1, 1'b0, 1'b1);
    for (int c = 0; c < DIV_LAT + 6; c++) begin
      cycle('0, 1'b0, 1'b0);
      chk("rstmid_rsp_valid", 32'(s_rv), 32'd0);
      if (c == 0) chk("rstmid_inflight", 32'(s_infl), 32'd0);
    end
    cycle('1, 1'b0, 1'b0);
    chk("rstmid_first_grant", 32'(s_gnt), 32'd1);

    // Partial contention, then a lone requester
    for (int c = 0; c < 3; c++) begin
      cycle(4'b1010, 1'b0, 1'b0);
      chk("partial_grant", 32'(s_gnt), (c % 2 == 0) ? 32'd2 : 32'd8);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      chk("single_grant", 32'(s_gnt), 32'd4);
    end
    for (int c = 0; c < DIV_LAT + 6; c++) cycle('0, 1'b0, 1'b0);

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      cycle(NREQ'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 49) == 0);
    end
    for (int c = 0; c < DIV_LAT + 6; c++) cycle('0, 1'b0, 1'b0);
    chk("final_inflight", 32'(s_infl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
